irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
// - Interrupt controller feeding the core's single irq line: collects NSRC peripheral
//   requests, applies mask and fixed priority, drives irq_out to the core, and
//   exposes a cause register so the handler at 0x1 can identify the source.
// - Lives next to the core's special-register file and is accessed via the same
//   sel/in/ie register protocol as the core's special registers.
// PARAMETERS
// - NSRC      8        number of interrupt sources (1..15)
// - BASE_SEL  16'h0040 reg_sel of register 0; registers at BASE_SEL+0..+3
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      asynchronous, active-high reset
// - src_in      in   NSRC   raw peripheral requests, synchronous to clk
// - cpu_irq_en  in   1      core interrupt-enable flag (rt_mode bit 2)
// - cpu_ack     in   1      1-cycle pulse: core has taken the vector jump to 0x1
// - irq_out     out  1      level request to the core
// - reg_sel     in   16     register select
// - reg_in      in   16     write data
// - reg_ie      in   1      write enable, 1 cycle
// - reg_out     out  16     combinational read data; 0 when sel is outside range
// BEHAVIOUR
// - Registers, at BASE_SEL+n:
//   - +0 PEND: bits[NSRC-1:0]; read pending; write 1 clears the bit (W1C).
//   - +1 MASK: 1 = source enabled.
//   - +2 CAUSE: bit15 = valid, [3:0] = id. Read-only; bit15 clears on read
//     (any cycle with reg_sel == +2 and ~reg_ie).
//   - +3 MODE: 1 = edge-sensitive, 0 = level.
//   - Reset values: PEND 0, MASK 0, CAUSE 0, MODE all-1.
// - Pending update, every cycle:
//   - edge source: bit set on a 0->1 of src_in vs a 1-cycle delayed copy.
//   - level source: bit = src_in.
//   - Same-cycle set and W1C on an edge bit: set wins.
// - Priority: lowest index wins among PEND & MASK.
// - FSM (reset to IDLE, irq_out = 0):
//   - IDLE: if cpu_irq_en & |(PEND&MASK): latch winner id into cur_id, irq_out <= 1, go REQ.
//   - REQ: hold irq_out = 1 and cur_id. Later mask/PEND changes do not withdraw it.
//     On cpu_ack: CAUSE <= {1, cur_id}; clear PEND[cur_id] if edge; irq_out <= 0;
//     go DROP. Level sources are cleared by the device, not by ack.
//   - DROP: wait for cpu_irq_en == 0 (core clears it the cycle after irq falls),
//     then go IDLE. A new request is possible only after software re-enables.
// - Latency: enabled pending bit -> irq_out high is 1 cycle; cpu_ack -> irq_out low is 1 cycle.
// - cpu_ack outside REQ is ignored.
// - cpu_irq_en falling while in REQ: stay in REQ. Core only drops it after ack.
// - Register write and FSM clear on the same PEND bit in one cycle: both apply (bit 0).
// - Reset mid-REQ: irq_out drops asynchronously and all state is cleared.
// - Widths: id is 4 bits, zero-extended; unused PEND/MASK/MODE bits read 0 and
//   ignore writes.
// STRUCTURE
// - irq_pkg: register offset localparams (PEND/MASK/CAUSE/MODE), FSM state enum
//   (IDLE/REQ/DROP), ID_W = 4.
// - Sub-module irq_prio_enc: combinational NSRC-bit fixed-priority encoder ->
//   {any, id}; instantiated once.
// TESTING
// - Reset, MASK=0x01, MODE=0x01, pulse src_in[0] 1 cycle, cpu_irq_en=1
//   -> PEND=0x01, irq_out high next cycle; cpu_ack -> irq_out low, CAUSE=0x8000,
//   PEND=0x00.
// - MASK=0xFF, src_in[5] and src_in[2] rise together
//   -> cur_id=2, CAUSE=0x8002 after ack; after re-enable, second request gives
//   CAUSE=0x8005.
// - cpu_irq_en=0 with PEND&MASK=0x04 -> irq_out stays 0;
//   raise cpu_irq_en -> irq_out=1 one cycle later.
// - Level source 3 (MODE=0xF7, MASK=0x08), src_in[3] held high through ack
//   -> PEND bit stays set, DROP waits for cpu_irq_en=0, then re-request after
//   re-enable.
// - In REQ, write MASK=0 -> irq_out held; cpu_ack completes.
//   Assert rst mid-REQ -> irq_out=0 immediately, all regs at reset values.
// - Write PEND W1C=0x02 in the same cycle as a new edge on src_in[1] -> PEND[1]=1;
//   read CAUSE twice -> second read has bit15=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states, id width.
package irq_pkg;

    localparam int ID_W = 4;

    localparam logic [15:0] OFF_PEND  = 16'd0;
    localparam logic [15:0] OFF_MASK  = 16'd1;
    localparam logic [15:0] OFF_CAUSE = 16'd2;
    localparam logic [15:0] OFF_MODE  = 16'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; any flags a non-empty request vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [ID_W-1:0] id
);

    always_comb begin
        any = |req;
        id  = '0;
        // Scan downward so the lowest active index is the last one written.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask/mode registers, fixed priority, and a request
// handshake with the core over irq_out / cpu_ack / cpu_irq_en.
//
// state | meaning
// IDLE  | no request outstanding; waiting for cpu_irq_en and an enabled pending source
// REQ   | irq_out held high with cur_id latched; waiting for cpu_ack
// DROP  | request taken; waiting for the core to clear cpu_irq_en before re-arming
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NSRC     = 8,
    parameter logic [15:0] BASE_SEL = 16'h0040
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_in,
    input  logic            cpu_irq_en,
    input  logic            cpu_ack,
    output logic            irq_out,
    input  logic [15:0]     reg_sel,
    input  logic [15:0]     reg_in,
    input  logic            reg_ie,
    output logic [15:0]     reg_out
);

    localparam logic [NSRC-1:0] ONE_HOT0 = NSRC'(1);

    logic [NSRC-1:0] pend, mask, mode, src_d;
    logic [NSRC-1:0] pend_nxt, w1c, fsm_clr, edge_set;
    logic            cause_valid;
    logic [ID_W-1:0] cause_id;
    logic [ID_W-1:0] cur_id, win_id;
    logic            win_any;
    logic [15:0]     off;
    logic            wr_pend, wr_mask, wr_mode, rd_cause;
    irq_state_e      state, state_nxt;
    logic            irq_nxt, load_id, ack_take;
    logic            unused_reg_in;

    assign unused_reg_in = ^reg_in[15:NSRC];

    assign off      = reg_sel - BASE_SEL;
    assign wr_pend  = reg_ie & (off == OFF_PEND);
    assign wr_mask  = reg_ie & (off == OFF_MASK);
    assign wr_mode  = reg_ie & (off == OFF_MODE);
    assign rd_cause = ~reg_ie & (off == OFF_CAUSE);

    assign w1c      = wr_pend ? reg_in[NSRC-1:0] : '0;
    assign fsm_clr  = ack_take ? (ONE_HOT0 << cur_id) : '0;
    assign edge_set = src_in & ~src_d;

    // Edge bits: new edge beats any clear in the same cycle. Level bits track the pin.
    assign pend_nxt = (mode & ((pend & ~w1c & ~fsm_clr) | edge_set))
                    | (~mode & src_in);

    irq_prio_enc #(.NSRC(NSRC)) u_prio (
        .req (pend & mask),
        .any (win_any),
        .id  (win_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= '0;
            mask        <= '0;
            mode        <= '1;
            src_d       <= '0;
            cause_valid <= 1'b0;
            cause_id    <= '0;
        end else begin
            pend  <= pend_nxt;
            src_d <= src_in;
            if (wr_mask) mask <= reg_in[NSRC-1:0];
            if (wr_mode) mode <= reg_in[NSRC-1:0];
            if (ack_take) begin
                cause_valid <= 1'b1;
                cause_id    <= cur_id;
            end else if (rd_cause) begin
                cause_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irq_out <= 1'b0;
            cur_id  <= '0;
        end else begin
            state   <= state_nxt;
            irq_out <= irq_nxt;
            if (load_id) cur_id <= win_id;
        end
    end

    always_comb begin
        state_nxt = state;
        irq_nxt   = irq_out;
        load_id   = 1'b0;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_irq_en && win_any) begin
                    load_id   = 1'b1;
                    irq_nxt   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (cpu_ack) begin
                    ack_take  = 1'b1;
                    irq_nxt   = 1'b0;
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (!cpu_irq_en) state_nxt = IDLE;
            end
            default: begin
                irq_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        reg_out = '0;
        case (off)
            OFF_PEND:  reg_out = 16'(pend);
            OFF_MASK:  reg_out = 16'(mask);
            OFF_CAUSE: reg_out = {cause_valid, {(15 - ID_W){1'b0}}, cause_id};
            OFF_MODE:  reg_out = 16'(mode);
            default:   reg_out = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus queues expected values, a negedge monitor drains them.
module tb_irq_ctrl;
    localparam int          NSRC = 8;
    localparam logic [15:0] BASE = 16'h0040;

    logic            clk, rst;
    logic [NSRC-1:0] src_in;
    logic            cpu_irq_en, cpu_ack, irq_out, reg_ie;
    logic [15:0]     reg_sel, reg_in, reg_out;

    typedef struct {
        string       name;
        bit          is_reg;
        logic [15:0] exp;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    irq_ctrl #(.NSRC(NSRC), .BASE_SEL(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_in     (src_in),
        .cpu_irq_en (cpu_irq_en),
        .cpu_ack    (cpu_ack),
        .irq_out    (irq_out),
        .reg_sel    (reg_sel),
        .reg_in     (reg_in),
        .reg_ie     (reg_ie),
        .reg_out    (reg_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every queued expectation belongs to the cycle in progress.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t it;
            logic [15:0] act;
            it = q.pop_front();
            act = it.is_reg ? reg_out : {15'b0, irq_out};
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        reg_ie  = 1'b0;
        reg_sel = 16'h0000;
        reg_in  = 16'h0000;
    endtask

    task automatic chk_irq(input logic v, input string name);
        item_t it;
        it.name = name; it.is_reg = 1'b0; it.exp = {15'b0, v};
        q.push_back(it);
    endtask

    task automatic rd_raw(input logic [15:0] sel, input logic [15:0] exp, input string name);
        item_t it;
        reg_sel = sel;
        it.name = name; it.is_reg = 1'b1; it.exp = exp;
        q.push_back(it);
        tick();
    endtask

    task automatic rd(input int o, input logic [15:0] exp, input string name);
        rd_raw(BASE + 16'(o), exp, name);
    endtask

    task automatic wr(input int o, input logic [15:0] data);
        reg_sel = BASE + 16'(o);
        reg_in  = data;
        reg_ie  = 1'b1;
        tick();
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src_in = '0; cpu_irq_en = 1'b0; cpu_ack = 1'b0;
        reg_ie = 1'b0; reg_sel = 16'h0000; reg_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        chk_irq(1'b0, "rst_irq");
        rd(0, 16'h0000, "rst_pend");
        rd(1, 16'h0000, "rst_mask");
        rd(2, 16'h0000, "rst_cause");
        rd(3, 16'h00FF, "rst_mode");
        rd_raw(BASE + 16'd4, 16'h0000, "oor_hi");
        rd_raw(BASE - 16'd1, 16'h0000, "oor_lo");

        // Single edge source 0
        wr(1, 16'h0001);
        wr(3, 16'h0001);
        cpu_irq_en = 1'b1;
        src_in = 8'h01;
        tick();
        src_in = 8'h00;
        chk_irq(1'b0, "s1_irq_pre");
        rd(0, 16'h0001, "s1_pend");
        chk_irq(1'b1, "s1_irq_hi");
        ack();
        chk_irq(1'b0, "s1_irq_lo");
        rd(2, 16'h8000, "s1_cause");
        rd(0, 16'h0000, "s1_pend_clr");
        cpu_irq_en = 1'b0;
        tick();

        // Simultaneous sources 5 and 2: lowest index first
        wr(3, 16'h00FF);
        wr(1, 16'h00FF);
        cpu_irq_en = 1'b1;
        src_in = 8'h24;
        tick();
        tick();
        chk_irq(1'b1, "s2_irq_hi");
        ack();
        rd(2, 16'h8002, "s2_cause_a");
        chk_irq(1'b0, "s2_drop_hold");
        rd(0, 16'h0020, "s2_pend_rem");
        chk_irq(1'b0, "s2_drop_hold2");
        cpu_irq_en = 1'b0;
        tick();
        cpu_irq_en = 1'b1;
        tick();
        chk_irq(1'b1, "s2_irq_second");
        ack();
        rd(2, 16'h8005, "s2_cause_b");
        rd(0, 16'h0000, "s2_pend_empty");
        cpu_irq_en = 1'b0;
        tick();
        src_in = 8'h00;
        tick();

        // Enable gating
        src_in = 8'h04;
        tick();
        src_in = 8'h00;
        tick();
        tick();
        chk_irq(1'b0, "s3_gated");
        rd(0, 16'h0004, "s3_pend");
        cpu_irq_en = 1'b1;
        chk_irq(1'b0, "s3_before_en");
        tick();
        chk_irq(1'b1, "s3_after_en");
        ack();
        rd(2, 16'h8002, "s3_cause");
        cpu_irq_en = 1'b0;
        tick();

        // Level source 3
        wr(3, 16'h00F7);
        wr(1, 16'h0008);
        src_in = 8'h08;
        tick();
        cpu_irq_en = 1'b1;
        tick();
        chk_irq(1'b1, "s4_irq_hi");
        ack();
        chk_irq(1'b0, "s4_irq_lo");
        rd(0, 16'h0008, "s4_pend_level");
        rd(2, 16'h8003, "s4_cause");
        tick();
        chk_irq(1'b0, "s4_drop_wait");
        cpu_irq_en = 1'b0;
        tick();
        cpu_irq_en = 1'b1;
        tick();
        chk_irq(1'b1, "s4_rereq");

        // Mask removal in REQ does not withdraw the request
        wr(1, 16'h0000);
        chk_irq(1'b1, "s5_mask_hold");
        tick();
        chk_irq(1'b1, "s5_mask_hold2");
        ack();
        chk_irq(1'b0, "s5_ack_lo");
        rd(2, 16'h8003, "s5_cause");
        cpu_irq_en = 1'b0;
        tick();

        // Asynchronous reset mid-REQ
        wr(1, 16'h0008);
        cpu_irq_en = 1'b1;
        tick();
        chk_irq(1'b1, "s5_req_again");
        tick();
        rst = 1'b1;
        #1;
        chk_irq(1'b0, "s5_rst_async");
        cpu_irq_en = 1'b0;
        rd(0, 16'h0000, "s5_rst_pend");
        rd(1, 16'h0000, "s5_rst_mask");
        rd(2, 16'h0000, "s5_rst_cause");
        rd(3, 16'h00FF, "s5_rst_mode");
        src_in = 8'h00;
        rst = 1'b0;
        tick();

        // W1C against a new edge: set wins; plain W1C clears
        src_in = 8'h02;
        tick();
        src_in = 8'h00;
        tick();
        src_in = 8'h02;
        wr(0, 16'h0002);
        rd(0, 16'h0002, "s6_set_wins");
        wr(0, 16'h0002);
        rd(0, 16'h0000, "s6_w1c");

        // CAUSE valid clears on read; ack outside REQ ignored
        wr(1, 16'h0002);
        src_in = 8'h00;
        tick();
        src_in = 8'h02;
        tick();
        cpu_irq_en = 1'b1;
        tick();
        chk_irq(1'b1, "s6_irq_hi");
        ack();
        rd(2, 16'h8001, "s6_cause_first");
        rd(2, 16'h0001, "s6_cause_second");
        cpu_irq_en = 1'b0;
        tick();
        src_in = 8'h00;
        tick();
        src_in = 8'h02;
        tick();
        ack();
        rd(2, 16'h0001, "s6_stray_ack");
        chk_irq(1'b0, "s6_stray_irq");
        rd(0, 16'h0002, "s6_stray_pend");

        tick();
        tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0 items left", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
